dsm_mash111_dith: RTL and testbench
===================================

DSM_MASH111_DITH -- requirements
Module: dsm_mash111_dith

Interface
REQ-001 SHALL have parameter FRAC_W, default 16, fractional accumulator width (legal 8..24).
REQ-002 SHALL have parameter NINT_W, default 8, integer divide-ratio width.
REQ-003 SHALL have the following ports, all sampled or driven on the rising edge of CLK, except NRST:
- CLK  input  1  block clock.
- NRST  input  1  asynchronous active-low reset.
- EN  input  1  modulator enable.
- FRAC  input  FRAC_W  unsigned fractional word.
- FRAC_LD  input  1  load strobe for FRAC and N_INT.
- N_INT  input  NINT_W  unsigned integer divide ratio.
- DITH  input  6  unsigned dither word, driven by the upstream dither LFSR URN6B output.
- DSM_OUT  output  4  signed two's-complement MASH output, range -3..+4.
- DIV_N  output  NINT_W  divider ratio, N_INT plus DSM_OUT, saturated.
- DSM_VLD  output  1  DSM_OUT and DIV_N are valid.

Function
REQ-004 SHALL capture FRAC into frac_q and N_INT into nint_q on the CLK edge where FRAC_LD=1, independent of EN; the new values take effect from the next edge.
REQ-005 Stage 1 SHALL compute s1 = acc1 + frac_q + dith_term in FRAC_W+1 bits; c1 = s1[FRAC_W]; acc1 next = s1 modulo 2^FRAC_W.
REQ-006 Stage 2 SHALL compute s2 = acc2 + s1[FRAC_W-1:0] combinationally; c2 = carry; acc2 next = s2 modulo 2^FRAC_W.
REQ-007 Stage 3 SHALL compute s3 = acc3 + s2[FRAC_W-1:0] combinationally; c3 = carry; acc3 next = s3 modulo 2^FRAC_W.
REQ-008 SHALL register carry history c2_d1, c3_d1 and c3_d2.
REQ-009 SHALL register DSM_OUT <= c1 + c2 - c2_d1 + c3 - 2*c3_d1 + c3_d2, computed in 4-bit signed arithmetic.
REQ-010 SHALL register DIV_N <= nint_q + sign-extended y at the same edge as DSM_OUT, clamped to the range 0..2^NINT_W-1.
REQ-011 While EN=1, the accumulators, the history and the outputs SHALL all update on every edge.
REQ-012 SHALL count edges with EN=1 in a 2-bit saturating counter; DSM_VLD SHALL be 1 when the counter reaches 3, so it rises on the third enabled edge.
REQ-013 On any edge with EN=0, SHALL clear acc1, acc2, acc3, the history, the counter, DSM_OUT and DSM_VLD to 0, and set DIV_N to nint_q.
REQ-014 The EN 0->1 transition SHALL restart from a zero state, so the output sequence is repeatable for identical FRAC and DITH.
REQ-015 If FRAC_LD and EN are asserted on the same edge, the accumulators SHALL use the old frac_q at that edge.

Reset
REQ-016 On NRST=0, asynchronously and regardless of CLK, SHALL clear frac_q, nint_q, acc1-3, the history, the counter, DSM_OUT, DIV_N and DSM_VLD to 0.
REQ-017 After NRST deasserts, the block SHALL hold these zero values until the first enabled edge.

Configuration
REQ-018 Macro DSM_DITHER_EN: when defined, dith_term = DITH zero-extended; FRAC_LD SHALL capture min(FRAC, 2^FRAC_W-64) so that s1 < 2^(FRAC_W+1).
REQ-019 Without DSM_DITHER_EN, dith_term = 0, DITH SHALL be ignored, FRAC SHALL be captured unclamped, and no dither logic SHALL be synthesised.

Verification
REQ-020 Macro off, FRAC_W=16, FRAC=0, N_INT=40, FRAC_LD then EN=1 -> DSM_OUT=0 and DIV_N=40 on every edge; DSM_VLD=1 from the third enabled edge.
REQ-021 Macro off, FRAC=0x8000, N_INT=40 -> DSM_OUT always within -3..+4; the sum of DSM_OUT over the first 65536 enabled edges = 32768 +/- 4.
REQ-022 N_INT=0, FRAC=0x8000 -> DIV_N never wraps (minimum 0); N_INT=255, FRAC=0x8000 -> DIV_N maximum 255.
REQ-023 Macro on, FRAC=0xFFFF with FRAC_LD -> frac_q=0xFFC0; with DITH=63 held for 1000 edges, c1 never exceeds 1 and DSM_OUT stays in range.
REQ-024 EN dropped for 1 cycle mid-run -> the next edge gives DSM_OUT=0, DSM_VLD=0 and DIV_N=nint_q; after re-enable the sequence matches the first run edge for edge.
REQ-025 NRST pulsed low between edges mid-run -> all outputs are 0 immediately, with no wait for CLK; FRAC_LD is required again before a non-zero FRAC takes effect.

Source files
------------

// File: rtl/dsm_mash111_dith.sv
// dsm_mash111_dith: MASH 1-1-1 delta-sigma modulator driving a saturated integer divide ratio.
// Define DSM_DITHER_EN to add the DITH word into stage 1 and clamp loaded FRAC to 2^FRAC_W-64.
module dsm_mash111_dith #(
    parameter int FRAC_W = 16,
    parameter int NINT_W = 8
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic              EN,
    input  logic [FRAC_W-1:0] FRAC,
    input  logic              FRAC_LD,
    input  logic [NINT_W-1:0] N_INT,
    input  logic [5:0]        DITH,
    output logic [3:0]        DSM_OUT,
    output logic [NINT_W-1:0] DIV_N,
    output logic              DSM_VLD
);
    logic [FRAC_W-1:0] frac_q, frac_in, acc1, acc2, acc3;
    logic [NINT_W-1:0] nint_q, div_n;
    logic [FRAC_W:0]   s1, s2, s3, dith_term;
    logic              c2_d1, c3_d1, c3_d2;
    logic [1:0]        cnt;
    logic [3:0]        y;
    logic [NINT_W+1:0] div_sum;

`ifdef DSM_DITHER_EN
    // Headroom of 64 keeps acc1 + frac_q + DITH below 2^(FRAC_W+1), so c1 stays a single bit
    localparam logic [FRAC_W-1:0] FRAC_MAX = {{(FRAC_W-6){1'b1}}, 6'd0};
    assign dith_term = {{(FRAC_W-5){1'b0}}, DITH};
    assign frac_in   = (FRAC > FRAC_MAX) ? FRAC_MAX : FRAC;
`else
    logic unused_dith;
    assign unused_dith = ^DITH;
    assign dith_term   = '0;
    assign frac_in     = FRAC;
`endif

    always_comb begin
        s1 = {1'b0, acc1} + {1'b0, frac_q} + dith_term;
        s2 = {1'b0, acc2} + {1'b0, s1[FRAC_W-1:0]};
        s3 = {1'b0, acc3} + {1'b0, s2[FRAC_W-1:0]};
        y  = {3'b0, s1[FRAC_W]} + {3'b0, s2[FRAC_W]} - {3'b0, c2_d1}
           + {3'b0, s3[FRAC_W]} - {2'b0, c3_d1, 1'b0} + {3'b0, c3_d2};
        // Two guard bits: top bit flags underflow below 0, next flags overflow past 2^NINT_W-1
        div_sum = {2'b0, nint_q} + {{(NINT_W-2){y[3]}}, y};
        div_n   = div_sum[NINT_W+1] ? '0 : div_sum[NINT_W] ? '1 : div_sum[NINT_W-1:0];
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            frac_q <= '0;
            nint_q <= '0;
        end else if (FRAC_LD) begin
            frac_q <= frac_in;
            nint_q <= N_INT;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            acc1    <= '0;
            acc2    <= '0;
            acc3    <= '0;
            c2_d1   <= 1'b0;
            c3_d1   <= 1'b0;
            c3_d2   <= 1'b0;
            cnt     <= '0;
            DSM_OUT <= '0;
            DIV_N   <= '0;
        end else if (EN) begin
            acc1    <= s1[FRAC_W-1:0];
            acc2    <= s2[FRAC_W-1:0];
            acc3    <= s3[FRAC_W-1:0];
            c2_d1   <= s2[FRAC_W];
            c3_d1   <= s3[FRAC_W];
            c3_d2   <= c3_d1;
            cnt     <= (cnt == 2'd3) ? cnt : cnt + 2'd1;
            DSM_OUT <= y;
            DIV_N   <= div_n;
        end else begin
            acc1    <= '0;
            acc2    <= '0;
            acc3    <= '0;
            c2_d1   <= 1'b0;
            c3_d1   <= 1'b0;
            c3_d2   <= 1'b0;
            cnt     <= '0;
            DSM_OUT <= '0;
            DIV_N   <= nint_q;
        end
    end

    assign DSM_VLD = (cnt == 2'd3);
endmodule

// File: tb/tb_dsm_mash111_dith.sv
// tb_dsm_mash111_dith: randomized and directed checks of dsm_mash111_dith against an integer model.
module tb_dsm_mash111_dith;
    localparam int FW = 16;
    localparam int NW = 8;
    localparam longint M = 64'd1 << FW;

    logic          CLK = 1'b0;
    logic          NRST = 1'b0;
    logic          EN = 1'b0;
    logic [FW-1:0] FRAC = '0;
    logic          FRAC_LD = 1'b0;
    logic [NW-1:0] N_INT = '0;
    logic [5:0]    DITH = '0;
    logic [3:0]    DSM_OUT;
    logic [NW-1:0] DIV_N;
    logic          DSM_VLD;

    dsm_mash111_dith #(.FRAC_W(FW), .NINT_W(NW)) dut (
        .CLK(CLK), .NRST(NRST), .EN(EN), .FRAC(FRAC), .FRAC_LD(FRAC_LD),
        .N_INT(N_INT), .DITH(DITH), .DSM_OUT(DSM_OUT), .DIV_N(DIV_N), .DSM_VLD(DSM_VLD)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;

    // Model state: plain integer accumulators and a carry history
    longint m_frac = 0, a1 = 0, a2 = 0, a3 = 0;
    int m_nint = 0, c2p = 0, c3p1 = 0, c3p2 = 0, m_cnt = 0;
    int e_out = 0, e_div = 0, e_vld = 0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic ok(string nm, bit cond, int act);
        n_chk++;
        if (cond) n_pass++;
        else $display("FAIL %s: value %0d outside allowed bounds at %0t", nm, act, $time);
    endtask

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        m_frac = 0; m_nint = 0; a1 = 0; a2 = 0; a3 = 0;
        c2p = 0; c3p1 = 0; c3p2 = 0; m_cnt = 0;
        e_out = 0; e_div = 0; e_vld = 0;
    endtask

    // Predicts the state after the coming rising edge from the inputs now applied
    task automatic model_step();
        longint s, d;
        int k1, k2, k3, yv;
        if (!NRST) begin
            model_reset();
            return;
        end
        if (EN) begin
`ifdef DSM_DITHER_EN
            d = longint'(DITH);
`else
            d = 0;
`endif
            s = a1 + m_frac + d; k1 = (s >= M) ? 1 : 0; a1 = s % M;
            s = a2 + a1;         k2 = (s >= M) ? 1 : 0; a2 = s % M;
            s = a3 + a2;         k3 = (s >= M) ? 1 : 0; a3 = s % M;
            yv = k1 + (k2 - c2p) + (k3 - 2 * c3p1 + c3p2);
            c3p2 = c3p1; c3p1 = k3; c2p = k2;
            e_out = yv;
            e_div = clamp(m_nint + yv, 0, (1 << NW) - 1);
            m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
        end else begin
            a1 = 0; a2 = 0; a3 = 0; c2p = 0; c3p1 = 0; c3p2 = 0; m_cnt = 0;
            e_out = 0;
            e_div = m_nint;
        end
        if (FRAC_LD) begin
`ifdef DSM_DITHER_EN
            m_frac = (longint'(FRAC) > M - 64) ? M - 64 : longint'(FRAC);
`else
            m_frac = longint'(FRAC);
`endif
            m_nint = int'(N_INT);
        end
        e_vld = (m_cnt == 3) ? 1 : 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        chk("dsm_out", int'($signed(DSM_OUT)), e_out);
        chk("div_n", int'(DIV_N), e_div);
        chk("dsm_vld", int'(DSM_VLD), e_vld);
        ok("dsm_out_range", int'($signed(DSM_OUT)) >= -3 && int'($signed(DSM_OUT)) <= 4, int'($signed(DSM_OUT)));
    endtask

    task automatic load(int f, int n);
        FRAC = FW'(f);
        N_INT = NW'(n);
        FRAC_LD = 1'b1;
        tick();
        FRAC_LD = 1'b0;
    endtask

    int pin[4] = '{0, 2, -1, 1};
    int rec[40];
    int sum, mn, mx;

    initial begin
        #12;
        chk("reset_out", int'(DSM_OUT), 0);
        chk("reset_div", int'(DIV_N), 0);
        chk("reset_vld", int'(DSM_VLD), 0);
        @(negedge CLK);
        NRST = 1'b1;
        repeat (3) tick();
        chk("held_div", int'(DIV_N), 0);

        // Zero fraction: constant ratio, valid from the third enabled edge
        load(0, 40);
        EN = 1'b1;
        tick(); chk("z_vld1", int'(DSM_VLD), 0); chk("z_div1", int'(DIV_N), 40);
        tick(); chk("z_vld2", int'(DSM_VLD), 0);
        tick(); chk("z_vld3", int'(DSM_VLD), 1);
        repeat (20) tick();
        chk("z_out", int'($signed(DSM_OUT)), 0);
        chk("z_div", int'(DIV_N), 40);

        // Half fraction: hand-computed opening sequence and long-run mean
        EN = 1'b0;
        load(16'h8000, 40);
        EN = 1'b1;
        sum = 0;
        for (int i = 0; i < 65536; i++) begin
            tick();
            sum += int'($signed(DSM_OUT));
            if (i < 4) begin
                chk("half_pin_out", int'($signed(DSM_OUT)), pin[i]);
                chk("half_pin_div", int'(DIV_N), 40 + pin[i]);
            end
        end
        ok("half_sum", sum >= 32764 && sum <= 32772, sum);

        // Saturation at both ends of the divide ratio
        EN = 1'b0;
        load(16'h8000, 0);
        EN = 1'b1;
        mn = 1000; mx = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            mn = (int'(DIV_N) < mn) ? int'(DIV_N) : mn;
            mx = (int'(DIV_N) > mx) ? int'(DIV_N) : mx;
        end
        chk("low_min", mn, 0);
        ok("low_nowrap", mx <= 4, mx);
        EN = 1'b0;
        load(16'h8000, 255);
        EN = 1'b1;
        mn = 1000; mx = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            mn = (int'(DIV_N) < mn) ? int'(DIV_N) : mn;
            mx = (int'(DIV_N) > mx) ? int'(DIV_N) : mx;
        end
        chk("high_max", mx, 255);
        ok("high_nowrap", mn >= 252, mn);

        // One-cycle enable drop restarts the sequence from zero
        EN = 1'b0;
        load(int'($urandom_range(1, 65535)), 100);
        EN = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            rec[i] = e_out;
        end
        EN = 1'b0;
        tick();
        chk("drop_out", int'($signed(DSM_OUT)), 0);
        chk("drop_vld", int'(DSM_VLD), 0);
        chk("drop_div", int'(DIV_N), 100);
        EN = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("rerun_out", int'($signed(DSM_OUT)), rec[i]);
        end

        // Asynchronous reset between edges clears everything, including the loaded fraction
        #2 NRST = 1'b0;
        model_reset();
        #1;
        chk("arst_out", int'(DSM_OUT), 0);
        chk("arst_div", int'(DIV_N), 0);
        chk("arst_vld", int'(DSM_VLD), 0);
        #1 NRST = 1'b1;
        FRAC = 16'h8000;
        N_INT = 8'd77;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_out", int'($signed(DSM_OUT)), 0);
            chk("post_rst_div", int'(DIV_N), 0);
        end

`ifdef DSM_DITHER_EN
        // Full-scale fraction with maximum dither
        EN = 1'b0;
        load(16'hFFFF, 10);
        DITH = 6'd63;
        EN = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (i == 1) chk("dith_pin", int'($signed(DSM_OUT)), 3);
        end
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            EN = ($urandom_range(0, 15) != 0);
            FRAC_LD = ($urandom_range(0, 31) == 0);
            FRAC = FW'($urandom);
            N_INT = NW'($urandom);
            DITH = 6'($urandom);
            tick();
        end
        FRAC_LD = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
